prefetch_mem_queue: RTL

Downstream neighbour of the correlation prefetcher: sits between the prefetcher's memory-side port and main memory. Buffers single-cycle memory_io_req32 pulses in an in-order FIFO and issues them to memory one at a time. It also coalesces duplicate reads and returns each memory response upstream. Removes request loss when the prefetcher issues back-to-back demand and prefetch traffic while memory is busy.

---
 rtl/prefetch_mem_queue.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/prefetch_mem_queue.sv
// prefetch_mem_queue: in-order request FIFO between the correlation prefetcher and main memory.
// Coalesces duplicate reads and issues one request at a time. Define PFQ_TIMEOUT_EN for the response timeout.

package pfq_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp32;

  function automatic logic is_read(input memory_io_req32 r);
    return (r.do_read != '0) && (r.do_write == '0);
  endfunction

endpackage

module prefetch_mem_queue
  import pfq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  memory_io_req32         up_req,
  output memory_io_rsp32         up_rsp,
  output memory_io_req32         mem_req,
  input  memory_io_rsp32         mem_rsp,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("prefetch_mem_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  memory_io_req32   fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic [0:0]       state_q, state_d;
  memory_io_req32   inflight_q, inflight_d;
  memory_io_req32   mem_req_q, mem_req_d;
  memory_io_rsp32   up_rsp_q, up_rsp_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic queued_hit, inflight_hit, coalesce;
  logic pop_fifo, bypass, new_req, push, drop;
  logic rsp_match;

  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    queued_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ({1'b0, PTR_W'(j) - rd_ptr_q} < count_q && is_read(fifo_q[j]) &&
          fifo_q[j].addr == up_req.addr)
        queued_hit = 1'b1;
    end
  end

  assign inflight_hit = (state_q == WAIT_RSP) && is_read(inflight_q) &&
                        (inflight_q.addr == up_req.addr);
  assign coalesce     = up_req.valid && is_read(up_req) && (queued_hit || inflight_hit);

  // An empty idle queue forwards the request straight to memory for single-cycle issue latency.
  assign pop_fifo = (state_q == IDLE) && (count_q != '0);
  assign bypass   = (state_q == IDLE) && (count_q == '0) && up_req.valid;
  assign new_req  = up_req.valid && !coalesce && !bypass;
  assign push     = new_req && ((count_q - OCC_W'(pop_fifo)) < OCC_W'(DEPTH));
  assign drop     = new_req && !push;

  assign rsp_match = mem_rsp.valid && (mem_rsp.addr == inflight_q.addr);

`ifdef PFQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no latch is inferred; only always_ff blocks use '<='.
  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    mem_req_d  = '0;
    up_rsp_d   = '0;
`ifdef PFQ_TIMEOUT_EN
    tmo_cnt_d  = (state_q == WAIT_RSP) ? tmo_cnt_q + 1'b1 : '0;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop_fifo) begin
          mem_req_d       = fifo_q[rd_ptr_q];
          mem_req_d.valid = 1'b1;
          inflight_d      = mem_req_d;
          state_d         = WAIT_RSP;
        end else if (bypass) begin
          mem_req_d  = up_req;
          inflight_d = up_req;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_match) begin
          up_rsp_d       = mem_rsp;
          up_rsp_d.valid = 1'b1;
          state_d        = IDLE;
        end
`ifdef PFQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          up_rsp_d.valid = 1'b1;
          up_rsp_d.addr  = inflight_q.addr;
          tmo_err_d      = 1'b1;
          state_d        = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  // NOTE: the payload array has no reset; count and pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= up_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      inflight_q <= '0;
      mem_req_q  <= '0;
      up_rsp_q   <= '0;
      drop_q     <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fifo) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_q + OCC_W'(push) - OCC_W'(pop_fifo);
      state_q    <= state_d;
      inflight_q <= inflight_d;
      mem_req_q  <= mem_req_d;
      up_rsp_q   <= up_rsp_d;
      drop_q     <= drop_d;
    end
  end

`ifdef PFQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign up_rsp     = up_rsp_q;
  assign mem_req    = mem_req_q;
  assign occupancy  = count_q;
  assign drop_count = drop_q;
  assign full       = (count_q == OCC_W'(DEPTH));
  assign empty      = (count_q == '0) && (state_q == IDLE);

endmodule
